heaa_share_arbiter: RTL and testbench
=====================================

Name: heaa_share_arbiter

Overview:
- Shares one HEAA-style approximate adder (lower INACC bits approximated, upper bits exact CLA) between two requesters.
- Each requester issues an operand pair plus an exact/approximate select over a valid/ready handshake.
- A round-robin arbiter grants one request per cycle into a single registered result slot that drains over a valid/ready response channel.
- Sits between the approximate-arithmetic datapath and its consumers (MAC/filter front-ends).

Parameters:
- WIDTH, 32, operand width; sum is WIDTH+1 bits.
- INACC, 11, number of approximated low bits; legal range 2..WIDTH-1.
- CNT_W, 16, width of the approximate-operation counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  operand A.
- req0_b  input  WIDTH  operand B.
- req0_exact  input  1  1 = exact add, 0 = approximate add.
- req1_valid, req1_ready, req1_a, req1_b, req1_exact: same as requester 0, for requester 1.
- rsp_valid  output  1  result slot holds a result.
- rsp_ready  input  1  consumer takes the result.
- rsp_sum  output  WIDTH+1  registered sum.
- rsp_id  output  1  requester that owns rsp_sum.
- approx_cnt  output  CNT_W  count of accepted approximate operations; wraps.

Behaviour:
- Reset: the synchronous, active-high rst clears all state.
  - rsp_valid=0, rsp_sum=0, rsp_id=0, approx_cnt=0.
  - Round-robin pointer = requester 0 has priority.
  - reqN_ready=0 while rst is high.
  - A request presented in the same cycle as rst is not accepted.
  - Reset mid-operation discards any held result.
- Approximate add, for i < INACC-1:
  - sum[i] = a[i] | b[i].
  - sum[INACC-1] = a^b at that bit.
  - c = a&b at bit INACC-1, used as carry-in to the upper part.
  - sum[WIDTH:INACC] = a[WIDTH-1:INACC] + b[WIDTH-1:INACC] + c (exact, carry-out lands in sum[WIDTH]).
- Exact add: sum = a + b, zero-extended to WIDTH+1.
- Slot free: slot_free = !rsp_valid || rsp_ready (a full slot that drains this cycle may be refilled in the same cycle).
- Grant:
  - Only when slot_free.
  - If exactly one reqN_valid, grant it.
  - If both, grant the pointer's requester; the pointer then moves to the other requester.
  - The pointer changes only on a contended grant.
  - reqN_ready is combinational = grant_N.
  - At most one ready per cycle; ready never asserts without valid.
- Accept cycle: rsp_sum, rsp_id and rsp_valid=1 are registered the next edge. Latency is 1 cycle, throughput 1 op/cycle under rsp_ready=1.
- Drain without new grant: rsp_valid clears to 0 on the edge.
- Hold: while rsp_valid && !rsp_ready, rsp_sum and rsp_id stay stable and both reqN_ready=0.
- approx_cnt: increments by 1 on each accepted request with exact=0; wraps from 2^CNT_W-1 to 0.
- Requesters must hold valid and operands stable until ready; behaviour on retracted valid is don't-care but must not corrupt the held result.

Test Plan:
- Approximate, carry out of approximated region: req0 a=0x00000FFF b=0x00000001 exact=0 → one cycle later rsp_valid=1, rsp_sum=0x0_00000FFF, rsp_id=0, approx_cnt=1. Same operands with exact=1 → 0x0_00001000, approx_cnt unchanged.
- Carry injection at bit INACC-1: a=b=0x00000400 exact=0 → rsp_sum=0x0_00000800. a=b=0xFFFFFFFF exact=0 → 0x1_FFFFFBFF; exact=1 → 0x1_FFFFFFFE.
- Contention: both valid every cycle, rsp_ready=1 → grants alternate 0,1,0,1, rsp_id follows one cycle later, one result per cycle.
- Backpressure: rsp_ready=0 for 3 cycles with slot full → rsp_sum stable, both ready=0. rsp_ready=1 with a request pending → drain and accept occur on the same edge, rsp_valid remains 1 with the new result.
- Reset mid-operation: rst=1 while rsp_valid=1 and both requesting → next edge rsp_valid=0, approx_cnt=0; first contended grant after reset goes to requester 0.
- Counter wrap (CNT_W=4): 17 approximate accepts → approx_cnt=1; interleaved exact ops do not count.

Source files
------------

// File: rtl/heaa_share_arbiter.sv
// Two-requester front end for a shared HEAA approximate adder. A round-robin
// arbiter feeds one registered result slot that drains over valid/ready.
module heaa_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int INACC = 11,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_exact,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_exact,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_sum,
    output logic             rsp_id,
    output logic [CNT_W-1:0] approx_cnt
);
    localparam int UP_W = WIDTH - INACC;

    logic             rsp_valid_q;
    logic [WIDTH:0]   rsp_sum_q;
    logic             rsp_id_q;
    logic [CNT_W-1:0] approx_cnt_q;
    logic             ptr_q;

    logic             slot_free;
    logic             contended;
    logic             grant0;
    logic             grant1;
    logic             grant_any;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_exact;
    logic [INACC-2:0] low_or;
    logic             pivot_x;
    logic             pivot_c;
    logic [UP_W:0]    upper_sum;
    logic [WIDTH:0]   approx_sum;
    logic [WIDTH:0]   exact_sum;
    logic [WIDTH:0]   rsp_sum_d;

    // A slot that drains this cycle can be refilled on the same edge.
    assign slot_free = !rsp_valid_q || rsp_ready;
    assign contended = req0_valid && req1_valid;
    assign grant0    = !rst && slot_free && req0_valid && (!req1_valid || !ptr_q);
    assign grant1    = !rst && slot_free && req1_valid && (!req0_valid || ptr_q);
    assign grant_any = grant0 || grant1;

    assign sel_a     = grant1 ? req1_a     : req0_a;
    assign sel_b     = grant1 ? req1_b     : req0_b;
    assign sel_exact = grant1 ? req1_exact : req0_exact;

    genvar gi;
    generate
        for (gi = 0; gi < INACC - 1; gi++) begin : g_low
            assign low_or[gi] = sel_a[gi] | sel_b[gi];
        end
    endgenerate

    // The top approximated bit generates the carry into the exact upper adder.
    assign pivot_x   = sel_a[INACC-1] ^ sel_b[INACC-1];
    assign pivot_c   = sel_a[INACC-1] & sel_b[INACC-1];
    assign upper_sum = {1'b0, sel_a[WIDTH-1:INACC]} + {1'b0, sel_b[WIDTH-1:INACC]}
                     + {{UP_W{1'b0}}, pivot_c};

    assign approx_sum = {upper_sum, pivot_x, low_or};
    assign exact_sum  = {1'b0, sel_a} + {1'b0, sel_b};
    assign rsp_sum_d  = sel_exact ? exact_sum : approx_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_id_q     <= 1'b0;
            approx_cnt_q <= '0;
            ptr_q        <= 1'b0;
        end else begin
            if (grant_any) begin
                rsp_valid_q <= 1'b1;
                rsp_sum_q   <= rsp_sum_d;
                rsp_id_q    <= grant1;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            if (grant_any && !sel_exact) begin
                approx_cnt_q <= approx_cnt_q + 1'b1;
            end
            if (grant_any && contended) begin
                ptr_q <= ~ptr_q;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_sum    = rsp_sum_q;
    assign rsp_id     = rsp_id_q;
    assign approx_cnt = approx_cnt_q;
endmodule

// File: tb/tb_heaa_share_arbiter.sv
// Randomized scoreboard bench for heaa_share_arbiter: grants are predicted from
// the arbitration rules, results from an arithmetic model of the HEAA adder.
module tb_heaa_share_arbiter;
    localparam int WIDTH = 32;
    localparam int INACC = 11;
    localparam int CNT_W = 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             exact;
        logic [WIDTH:0]   sum;
    } op_t;

    typedef struct {
        logic           id;
        logic [WIDTH:0] sum;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req0_exact;
    logic             req1_valid, req1_ready, req1_exact;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH:0]   rsp_sum;
    logic [CNT_W-1:0] approx_cnt;

    heaa_share_arbiter #(.WIDTH(WIDTH), .INACC(INACC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_exact(req0_exact),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_exact(req1_exact),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_id(rsp_id), .approx_cnt(approx_cnt)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    bit   gaps = 0;
    op_t  opq0[$];
    op_t  opq1[$];
    op_t  cur0, cur1;
    rsp_t exp_q[$];
    bit   g0 = 0, g1 = 0;
    bit   m_valid = 0, m_ptr = 0;
    logic [CNT_W-1:0] m_cnt = '0;
    bit   e0, e1, m_free;
    rsp_t r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic exact);
        longint unsigned la, lb, lo, piv, c, hi;
        la = 64'(a);
        lb = 64'(b);
        if (exact) return (WIDTH+1)'(la + lb);
        lo  = (la | lb) & ((64'd1 << (INACC - 1)) - 1);
        piv = ((la ^ lb) >> (INACC - 1)) & 1;
        c   = ((la & lb) >> (INACC - 1)) & 1;
        hi  = (la >> INACC) + (lb >> INACC) + c;
        return (WIDTH+1)'((hi << INACC) | (piv << (INACC - 1)) | lo);
    endfunction

    function automatic op_t mk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic exact);
        op_t o;
        o.a = a;
        o.b = b;
        o.exact = exact;
        o.sum = ref_sum(a, b, exact);
        return o;
    endfunction

    function automatic op_t mk_rand();
        logic [WIDTH-1:0] a, b;
        a = $urandom;
        b = $urandom;
        case ($urandom_range(3))
            0: begin a = '1; b = $urandom_range(1) != 0 ? '1 : b; end
            1: begin a = a & 32'hFFF; b = b & 32'hFFF; end
            default: ;
        endcase
        return mk(a, b, $urandom_range(1) != 0);
    endfunction

    // Requester drivers and response-ready generator.
    initial begin
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_exact = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_exact = 0;
        rsp_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            if (g0) req0_valid = 0;
            if (g1) req1_valid = 0;
            if (!req0_valid && opq0.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
                cur0 = opq0.pop_front();
                req0_a = cur0.a; req0_b = cur0.b; req0_exact = cur0.exact; req0_valid = 1;
            end
            if (!req1_valid && opq1.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
                cur1 = opq1.pop_front();
                req1_a = cur1.a; req1_b = cur1.b; req1_exact = cur1.exact; req1_valid = 1;
            end
            case (ready_mode)
                0:       rsp_ready = 1;
                1:       rsp_ready = $urandom_range(1) != 0;
                default: rsp_ready = 0;
            endcase
        end
    end

    // Grant predictor: checks readies, slot state and counter, pushes expected results.
    always @(negedge clk) begin
        cyc++;
        if (cyc > 1) begin
            chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
            chk("approx_cnt", 64'(approx_cnt), 64'(m_cnt));
            m_free = !m_valid || rsp_ready;
            e0 = !rst && m_free && req0_valid && (!req1_valid || !m_ptr);
            e1 = !rst && m_free && req1_valid && (!req0_valid || m_ptr);
            chk("req0_ready", 64'(req0_ready), 64'(e0));
            chk("req1_ready", 64'(req1_ready), 64'(e1));
            g0 = e0;
            g1 = e1;
            if (rst) begin
                m_valid = 0; m_ptr = 0; m_cnt = '0;
                exp_q.delete();
            end else if (e0 || e1) begin
                r.id  = e1;
                r.sum = e1 ? cur1.sum : cur0.sum;
                exp_q.push_back(r);
                m_valid = 1;
                if (!(e1 ? cur1.exact : cur0.exact)) m_cnt = m_cnt + 1'b1;
                if (req0_valid && req1_valid) m_ptr = !m_ptr;
            end else if (rsp_ready) begin
                m_valid = 0;
            end
        end else begin
            g0 = 0;
            g1 = 0;
        end
    end

    // Response monitor: compares whatever the slot presents against the queue head.
    always @(negedge clk) begin
        if (cyc > 1 && !rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got sum=%h id=%0d, expected no result", rsp_sum, rsp_id);
            end else begin
                chk("rsp_sum", 64'(rsp_sum), 64'(exp_q[0].sum));
                chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
                if (rsp_ready) begin
                    $display("rsp id=%0d sum=%h cnt=%0d", rsp_id, rsp_sum, approx_cnt);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drain();
        int t = 0;
        ready_mode = 0;
        gaps = 0;
        while ((opq0.size() > 0 || opq1.size() > 0 || req0_valid || req1_valid ||
                rsp_valid || exp_q.size() > 0) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 2000) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d cycles, expected < 2000", t);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Directed adder corners on requester 0.
        opq0.push_back(mk(32'h00000FFF, 32'h00000001, 0));
        opq0[0].sum = 33'h0_00000FFF;
        opq0.push_back(mk(32'h00000FFF, 32'h00000001, 1));
        opq0[1].sum = 33'h0_00001000;
        opq0.push_back(mk(32'h00000400, 32'h00000400, 0));
        opq0[2].sum = 33'h0_00000800;
        opq0.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 0));
        opq0[3].sum = 33'h1_FFFFFBFF;
        opq0.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1));
        opq0[4].sum = 33'h1_FFFFFFFE;
        drain();

        // Contention: both busy every cycle, grants alternate.
        for (int i = 0; i < 8; i++) begin
            opq0.push_back(mk_rand());
            opq1.push_back(mk_rand());
        end
        drain();

        // Backpressure with requests pending.
        for (int i = 0; i < 3; i++) begin
            opq0.push_back(mk_rand());
            opq1.push_back(mk_rand());
        end
        @(posedge clk);
        #2 ready_mode = 2;
        repeat (4) @(posedge clk);
        drain();

        // Reset mid-operation with a full slot and both requesting.
        for (int i = 0; i < 4; i++) begin
            opq0.push_back(mk_rand());
            opq1.push_back(mk_rand());
        end
        @(posedge clk);
        #2 ready_mode = 2;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        drain();

        // Counter wrap: 17 approximate ops with exact ops interleaved.
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 17; i++) begin
            opq0.push_back(mk($urandom, $urandom, 0));
            if (i % 3 == 0) opq1.push_back(mk($urandom, $urandom, 1));
        end
        drain();

        // Randomized traffic with random backpressure and idle gaps.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(1) != 0) opq0.push_back(mk_rand());
            else                        opq1.push_back(mk_rand());
        end
        ready_mode = 1;
        gaps = 1;
        repeat (600) @(posedge clk);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
